// File: rtl/bsnn_pkg.sv
// bsnn_pkg: shared types and constants for the spiking binary tile sequencer.
//   bsnn_seq_state_t : sequencer FSM state encoding
//   BSNN_*           : default tile geometry
//   bsnn_cnt_width   : width of the shared CLEAR/RUN phase counter
package bsnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } bsnn_seq_state_t;

  localparam int BSNN_N_NEURONS = 4;
  localparam int BSNN_DTT_WIDTH = 5;
  localparam int BSNN_TTD_WIDTH = 5;

  // The counter must be able to hold the larger of the two phase lengths.
  function automatic int bsnn_cnt_width(input int clr_cycles, input int max_cycles);
    int top;
    top = (clr_cycles > max_cycles) ? clr_cycles : max_cycles;
    return (top < 2) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/bsnn_seq_cnt.sv
// bsnn_seq_cnt: clearable saturating up-counter with terminal-count compare.
//   CLK, nRST : clock, asynchronous active-low reset
//   clr       : synchronous clear to zero (wins over en)
//   en        : count enable
//   limit     : terminal value for the compare
//   count     : current count
//   tc        : count == limit
module bsnn_seq_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      // Saturate so an unbounded RUN phase never wraps.
      count <= count + ONE;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/bsnn_seq_ctrl.sv
// bsnn_seq_ctrl: runs one inference at a time on a spiking binary tile.
// Accepts an input vector (in_valid/in_ready), holds tile_start low for
// CLR_CYCLES to clear membranes, raises tile_start until tile_finish, then
// offers the captured tile outputs (out_valid/out_ready).
//   CLK, nRST            : clock, asynchronous active-low reset
//   in_valid/in_ready    : input vector handshake, in_vector packed by lane
//   out_valid/out_ready  : result handshake, out_vector packed by lane
//   timeout_err          : result came from the watchdog (qualified by out_valid)
//   busy                 : sequencer not idle
//   tile_start           : low = clear/hold tile, high = run tile
//   tile_input_vector    : registered copy of the accepted vector
//   tile_output_vector   : tile outputs, tile_finish : tile done (level or pulse)
// Optional feature macro: BSNN_SEQ_WATCHDOG_EN enables the RUN-phase limit of
// MAX_CYCLES cycles; without it RUN waits indefinitely and timeout_err is 0.
module bsnn_seq_ctrl
  import bsnn_pkg::*;
#(
  parameter int N_NEURONS  = BSNN_N_NEURONS,
  parameter int DTT_WIDTH  = BSNN_DTT_WIDTH,
  parameter int TTD_WIDTH  = BSNN_TTD_WIDTH,
  parameter int CLR_CYCLES = 2,
  parameter int MAX_CYCLES = 64
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_NEURONS*DTT_WIDTH-1:0] in_vector,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_NEURONS*TTD_WIDTH-1:0] out_vector,
  output logic                           timeout_err,
  output logic                           busy,
  output logic                           tile_start,
  output logic [N_NEURONS*DTT_WIDTH-1:0] tile_input_vector,
  input  logic [N_NEURONS*TTD_WIDTH-1:0] tile_output_vector,
  input  logic                           tile_finish
);

  localparam int CNT_W = bsnn_cnt_width(CLR_CYCLES, MAX_CYCLES);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);

  bsnn_seq_state_t state, state_next;

  logic             in_ready_q;
  logic             accept;
  logic             capture;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;

  logic [N_NEURONS*DTT_WIDTH-1:0] in_vec_q;
  logic [N_NEURONS*TTD_WIDTH-1:0] out_vec_q;

`ifdef BSNN_SEQ_WATCHDOG_EN
  logic capture_to;
  logic timeout_q;
`endif

  bsnn_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // in_ready_q is only ever set in IDLE, so accept implies state == IDLE.
  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_limit  = CLR_LAST;
    capture    = 1'b0;
`ifdef BSNN_SEQ_WATCHDOG_EN
    capture_to = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = CLEAR;
          cnt_clr    = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_tc) begin
          state_next = RUN;
          cnt_clr    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RUN: begin
        cnt_limit = RUN_LAST;
        cnt_en    = 1'b1;
        // Finish is checked first so it wins over a coincident watchdog limit.
        if (tile_finish) begin
          state_next = DONE;
          capture    = 1'b1;
        end
`ifdef BSNN_SEQ_WATCHDOG_EN
        else if (cnt_tc) begin
          state_next = DONE;
          capture    = 1'b1;
          capture_to = 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- state and control registers ----
  // in_ready is registered from the next state so it is low during reset
  // and rises only on the first edge after release or return to IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next == IDLE);
    end
  end

  // ---- data registers ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      in_vec_q  <= '0;
      out_vec_q <= '0;
    end else begin
      if (accept) begin
        in_vec_q <= in_vector;
      end
      if (capture) begin
        out_vec_q <= tile_output_vector;
      end
    end
  end

`ifdef BSNN_SEQ_WATCHDOG_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      timeout_q <= 1'b0;
    end else if (capture) begin
      timeout_q <= capture_to;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready          = in_ready_q;
  assign out_valid         = (state == DONE);
  assign busy              = (state != IDLE);
  assign tile_start        = (state == RUN);
  assign out_vector        = out_vec_q;
  assign tile_input_vector = in_vec_q;

endmodule

// File: tb/tb_bsnn_seq_ctrl.sv
module tb_bsnn_seq_ctrl;

  localparam int NN = 4;
  localparam int DW = 5;
  localparam int TW = 5;
  localparam int CLR = 2;
  localparam int MAXC = 8;

  logic              CLK;
  logic              nRST;
  logic              in_valid;
  logic              in_ready;
  logic [NN*DW-1:0]  in_vector;
  logic              out_valid;
  logic              out_ready;
  logic [NN*TW-1:0]  out_vector;
  logic              timeout_err;
  logic              busy;
  logic              tile_start;
  logic [NN*DW-1:0]  tile_input_vector;
  logic [NN*TW-1:0]  tile_output_vector;
  logic              tile_finish;

  typedef struct {
    logic [NN*TW-1:0] vec;
    logic             to;
    logic [NN*DW-1:0] vin;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bsnn_seq_ctrl #(
    .N_NEURONS  (NN),
    .DTT_WIDTH  (DW),
    .TTD_WIDTH  (TW),
    .CLR_CYCLES (CLR),
    .MAX_CYCLES (MAXC)
  ) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_vector          (in_vector),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_vector         (out_vector),
    .timeout_err        (timeout_err),
    .busy               (busy),
    .tile_start         (tile_start),
    .tile_input_vector  (tile_input_vector),
    .tile_output_vector (tile_output_vector),
    .tile_finish        (tile_finish)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 50 && !in_ready; c++) tick();
    check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // From the first CLEAR cycle until out_valid: drives tile_finish, counts
  // CLEAR and RUN cycles and checks them against the expected lengths.
  task automatic run_part(input logic [NN*TW-1:0] vout, input int fin_cycle,
                          input logic fin_in_clear, input int exp_runs);
    int clr_cnt = 0;
    int run_cnt = 0;
    tile_output_vector = vout;
    for (int c = 0; c < 200 && !out_valid; c++) begin
      if (!tile_start) begin
        if (busy) clr_cnt++;
        tile_finish = fin_in_clear;
      end else begin
        run_cnt++;
        tile_finish = (run_cnt == fin_cycle);
      end
      tick();
    end
    tile_finish = 1'b0;
    check("done_reached", 32'(out_valid), 32'd1);
    check("clear_cycles", 32'(clr_cnt), 32'(CLR));
    check("run_cycles", 32'(run_cnt), 32'(exp_runs));
  endtask

  // Compares the offered result against the scoreboard head (no clock edge).
  task automatic collect();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_vector", 32'(out_vector), 32'(e.vec));
      check("timeout_err", 32'(timeout_err), 32'(e.to));
      check("tile_in_hold", 32'(tile_input_vector), 32'(e.vin));
      check("done_start_low", 32'(tile_start), 32'd0);
      check("done_not_ready", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic run_job(input logic [NN*DW-1:0] vin, input logic [NN*TW-1:0] vout,
                         input int fin_cycle, input logic exp_to, input int exp_runs);
    exp_t e;
    wait_ready();
    in_valid  = 1'b1;
    in_vector = vin;
    tick();
    in_valid  = 1'b0;
    e.vec = vout; e.to = exp_to; e.vin = vin;
    sb.push_back(e);
    run_part(vout, fin_cycle, 1'b0, exp_runs);
    collect();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("released_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic seen;
    nRST = 1'b0; in_valid = 1'b0; in_vector = '0; out_ready = 1'b0;
    tile_output_vector = '0; tile_finish = 1'b0;

    // ---- 1: reset then idle ----
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_tile_start", 32'(tile_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    nRST = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_tile_start", 32'(tile_start), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_timeout", 32'(timeout_err), 32'd0);

    // ---- 2: basic run ----
    in_valid = 1'b1; in_vector = 20'h12345;
    tick();
    in_valid = 1'b0;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_in_ready", 32'(in_ready), 32'd0);
    check("acc_start_low", 32'(tile_start), 32'd0);
    check("acc_tile_in", 32'(tile_input_vector), 32'h12345);
    e.vec = 20'h0ABCD; e.to = 1'b0; e.vin = 20'h12345;
    sb.push_back(e);
    run_part(20'h0ABCD, 5, 1'b0, 5);
    collect();

    // ---- 3: output backpressure ----
    tile_output_vector = 20'hFFFFF;
    in_valid = 1'b1; in_vector = 20'h54321;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_vector", 32'(out_vector), 32'h0ABCD);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_tile_in", 32'(tile_input_vector), 32'h12345);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check("bp_idle_tile_in", 32'(tile_input_vector), 32'h12345);

    // ---- 4: watchdog ----
`ifdef BSNN_SEQ_WATCHDOG_EN
    run_job(20'h00111, 20'h15A5A, 0, 1'b1, MAXC);
`else
    run_job(20'h00111, 20'h15A5A, 30, 1'b0, 30);
`endif
    run_job(20'h00222, 20'h0C3C3, MAXC, 1'b0, MAXC);

    // ---- 5: reset mid-RUN ----
    wait_ready();
    in_valid = 1'b1; in_vector = 20'h0F0F0;
    tick();
    in_valid = 1'b0;
    tile_output_vector = 20'h11111;
    for (int c = 0; c < 20 && !tile_start; c++) tick();
    tick(); tick();   // now in RUN cycle 3
    check("mid_run_start", 32'(tile_start), 32'd1);
    nRST = 1'b0;
    #1;
    check("abort_tile_start", 32'(tile_start), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_tile_in", 32'(tile_input_vector), 32'd0);
    tick();
    nRST = 1'b1;
    tile_finish = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    tile_finish = 1'b0;
    check("abort_no_result", 32'(seen), 32'd0);
    run_job(20'h0A0A0, 20'h05050, 2, 1'b0, 2);

    // ---- 6: back-to-back with finish during CLEAR ----
    wait_ready();
    out_ready = 1'b1;
    in_valid = 1'b1; in_vector = 20'h13579;
    tick();
    in_vector = 20'h02468;  // second vector held by producer
    e.vec = 20'h1F00F; e.to = 1'b0; e.vin = 20'h13579;
    sb.push_back(e);
    run_part(20'h1F00F, 3, 1'b0, 3);
    collect();
    tick();
    check("b2b_idle_busy", 32'(busy), 32'd0);
    check("b2b_idle_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_tile_in", 32'(tile_input_vector), 32'h13579);
    tick();
    in_valid = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_accept_tile_in", 32'(tile_input_vector), 32'h02468);
    e.vec = 20'h00F0F; e.to = 1'b0; e.vin = 20'h02468;
    sb.push_back(e);
    run_part(20'h00F0F, 4, 1'b1, 4);
    collect();
    tick();
    out_ready = 1'b0;
    check("b2b_end_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
